// File: rtl/keypad_pkg.sv
// Shared types, sizes and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, PRESS, HELD, RELEASE} state_t;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  localparam logic [ROWS-1:0] NO_ROW = 4'hF;

  // One-cold column drive for a column index.
  function automatic logic [COLS-1:0] col_drive(input logic [1:0] idx);
    logic [COLS-1:0] one_hot;
    one_hot = COLS'(1) << idx;
    return ~one_hot;
  endfunction

  // Lowest row index reading low; only meaningful when rows != NO_ROW.
  function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the key event outputs; master is the scanner side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [ROWS-1:0]  row_in;
  logic [COLS-1:0]  col_out;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_held
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_held
  );

endinterface

// File: rtl/keypad_tick_gen.sv
// Scan-step divider: one-cycle tick every SCAN_DIV clocks, combinational from the count.
// Free-running from reset; no backpressure.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan + debounce; key_valid lands one cycle after the accepting tick.
// Outputs are registered events with no backpressure; one key is tracked at a time.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic             tick;
  logic [ROWS-1:0]  rs_meta;
  logic [ROWS-1:0]  rs;
  state_t           state;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [DW-1:0]    deb_cnt;
  logic [COLS-1:0]  col_q;
  logic [KEY_W-1:0] code_q;
  logic             valid_q;
  logic             held_q;

  logic       row_low;
  logic       deb_done;
  logic [1:0] col_next;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Rows idle high, so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_meta <= NO_ROW;
      rs      <= NO_ROW;
    end else begin
      rs_meta <= kp.row_in;
      rs      <= rs_meta;
    end
  end

  assign row_low  = ~rs[row_idx];
  assign col_next = col_idx + 2'd1;
  // The increment about to happen is the one that reaches DEBOUNCE.
  assign deb_done = (deb_cnt == DW'(DEBOUNCE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      deb_cnt <= '0;
      col_q   <= col_drive(2'd0);
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (rs == NO_ROW) begin
              col_idx <= col_next;
              col_q   <= col_drive(col_next);
            end else begin
              row_idx <= lowest_low(rs);
              deb_cnt <= DW'(1);
              state   <= PRESS;
            end
          end
          PRESS: begin
            if (row_low) begin
              if (deb_done) begin
                code_q  <= {row_idx, col_idx};
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                state   <= HELD;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_next;
              col_q   <= col_drive(col_next);
            end
          end
          HELD: begin
            if (!row_low) begin
              deb_cnt <= DW'(1);
              state   <= RELEASE;
            end
          end
          RELEASE: begin
            if (!row_low) begin
              if (deb_done) begin
                held_q  <= 1'b0;
                state   <= SCAN;
                col_idx <= col_next;
                col_q   <= col_drive(col_next);
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign kp.col_out   = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low switch matrix by driving one column low at a time and reading the rows back. Debounces a single pressed key and reports its 4-bit code with a one-cycle valid pulse plus a held level. It is the input-side counterpart of the board's LED matrix scan logic. It feeds key events to the traffic-light and display control logic on the same board.

## Interface
- `SCAN_DIV`, default 1000: clk cycles per scan step; must be ≥ 4.
- `DEBOUNCE`, default 4: consecutive agreeing scan samples required for press and release; must be ≥ 2.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `row_in` in 4: keypad rows, pulled up; a pressed key pulls its row low; asynchronous to `clk`.
- `col_out` out 4: one-cold column drive; bit c low means column c is driven.
- `key_code` out 4: `{row[1:0], col[1:0]}` of the last accepted key.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_held` out 1: high from acceptance until release is accepted.

## Operation
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, state SCAN, column index 0, all counters 0.
- **Synchronizer:** `row_in` passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- **Tick:** a divider counts 0..`SCAN_DIV`-1. `tick` is high for one cycle when the count equals `SCAN_DIV`-1. All FSM decisions occur only on `tick`.
- **Captured row:** when `rs` != 4'hF, the captured row is the lowest index r with `rs[r]`=0.
- **SCAN:**
  - On tick, if `rs` == 4'hF: advance the column index (3 wraps to 0).
  - Otherwise: capture row r, freeze the column, set the debounce count to 1, go to PRESS.
- **PRESS:**
  - On tick, if `rs[r]`=0: increment the count.
  - When the count reaches `DEBOUNCE`: load `key_code`={r,col}, pulse `key_valid`, set `key_held`=1, go to HELD.
  - If `rs[r]`=1 on any tick: go to SCAN, advance the column, no output change.
- **HELD:** on tick, if `rs[r]`=1: set the count to 1 and go to RELEASE.
- **RELEASE:**
  - On tick, if `rs[r]`=1: increment the count.
  - When the count reaches `DEBOUNCE`: clear `key_held`, go to SCAN, advance the column.
  - If `rs[r]`=0: return to HELD. No new `key_valid`; `key_held` stays 1.
- **Multiple keys:**
  - While the column is frozen, keys in other columns are ignored.
  - Other rows in the frozen column are ignored.
  - Two keys in one column resolve to the lower row index.
- **Reset mid-operation:** returns immediately to the reset values. A key pressed across reset must be re-debounced from SCAN.

## Timing
- `col_out` is registered and changes one cycle after the tick that advances the column. A column is therefore driven for `SCAN_DIV` cycles before being sampled.
- `rs` lags `row_in` by 2 cycles. Because `SCAN_DIV` ≥ 4, the sample is settled.
- Press latency: `key_valid` is asserted in the cycle after the tick on which the count reaches `DEBOUNCE`. That is (`DEBOUNCE`-1)·`SCAN_DIV`+1 cycles after the detection tick.
- `key_valid` is never high for two consecutive cycles.
- `key_code` changes only in the cycle `key_valid` is high and holds between accepted presses.
- `key_held` rises together with `key_valid`. It falls one cycle after the tick completing the release.
- Worst-case time to detect a press: 4·`SCAN_DIV` cycles of scanning, plus debounce.

## Structure
- **Shared package `keypad_pkg`:**
  - state enum {SCAN, PRESS, HELD, RELEASE};
  - `KEY_W`=4, `ROWS`=4, `COLS`=4;
  - `NO_ROW`=4'hF.
- **Sub-module `keypad_tick_gen`:** the `SCAN_DIV` divider producing the one-cycle `tick`; `clk`/`rst` only.
- **Top module:** synchronizer, column counter, debounce counter, FSM and output registers live in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3.

1. **Reset and idle scan:** release `rst` with `row_in`=4'hF. `col_out` cycles 1110→1101→1011→0111→1110, changing every 4 cycles; `key_valid` and `key_held` stay 0.
2. **Clean press:** model key (row 2, col 1), pulling `row_in[2]` low only while `col_out[1]`=0, held 40 cycles. Exactly one `key_valid` pulse, `key_code`=4'b1001, and `key_held`=1. After release plus 3 ticks, `key_held`=0.
3. **Bounce:** press (row 0, col 3) for 1 tick, release for 1 tick, then hold. There is no pulse from the first glitch. One pulse with `key_code`=4'b0011 follows 3 stable ticks.
4. **Release bounce:** while key (1,0) is held, release for 1 tick then re-press. `key_held` stays 1 and no second `key_valid`. A final 3-tick release clears `key_held`.
5. **Simultaneous keys:** (row 3, col 2) and (row 1, col 2) are held together. `key_code`=4'b0110 (lower row). A key in col 0 pressed during HELD produces no event.
6. **Reset mid-operation:** assert `rst` during PRESS, after count 2. Outputs return to their reset values asynchronously. After `rst` releases, the still-held key needs a full 3-tick debounce before `key_valid`.
